decode_process: RTL and testbench
=================================

# decode_process

Steganographic decoder for the 64x64 image pipeline: recovers the character string hidden in the encoded image by comparing each encoded pixel with the same pixel of the compressed (pre-encoding) image. It walks the image in 4x4 blocks, extracts one base-3 digit per pixel, and converts each block's 16 trits into one 16-bit chunk (two characters) via a base-3-to-base-2 sub-module. It is the receive-side counterpart of the grayscale/compress/encode process block and shares its row/col pixel-addressing convention.

## Interface
- STR_LEN, 512: characters to recover; must be even and ≤512. Block count is NUM_BLOCKS = STR_LEN/2.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to begin decoding
- in_pix  in  24  encoded-image pixel at [row,col] (R 23:16, G 15:8, B 7:0); asynchronous read
- ref_pix  in  24  compressed-image pixel at [row,col]; asynchronous read
- row, col  out  6  registered pixel address
- busy  out  1  high from start acceptance until decode_done
- out_string  out  8*STR_LEN  recovered string; chunk k drives bits [16k+15:16k]
- decode_done  out  1  level; high once all chunks are stored
- err  out  1  sticky invalid-pixel flag (see Configuration)

## Operation
- Only green channels (bits 15:8) are used. d = in_pix[15:8] − ref_pix[15:8] mod 256.
- Trit mapping: d=0x00→0, d=0x01→1, d=0xFF→2. Wrap is intentional: ref 0x00 / enc 0xFF gives 2; ref 0xFF / enc 0x00 gives 1.
- Block b (0..NUM_BLOCKS−1), pixel p (0..15): row = 4·b[7:4] + p[3:2], col = 4·b[3:0] + p[1:0]. Blocks are row-major over the 16x16 block grid. Pixels are row-major within the block.
- Pixel p's trit is base-3 digit p, with p=0 least significant. Chunk = (Σ t_p·3^p) truncated to 16 bits.
- FSM states:
  - IDLE: start=1 goes to READ.
  - READ: 16 cycles, one pixel sampled per cycle into a 32-bit trit register.
  - CONV: pulses conv_en for 1 cycle, then waits for conv_done.
  - STORE: 1 cycle, writes the chunk. Goes to READ for the next block, or to DONE after the last block.
  - DONE: stays until start or reset.
- Arithmetic width: the Horner accumulator is 26 bits (3^16−1 < 2^26). Only the low 16 bits are stored.
- start while busy is ignored.
- start in DONE restarts: clears out_string, decode_done and err, then enters READ.
- rst_n low at any cycle, including mid-block or mid-conversion, returns to IDLE and aborts the converter.

## Timing
- Reset values: row=0, col=0, busy=0, out_string=0, decode_done=0, err=0, FSM=IDLE.
- row/col are updated each READ cycle. in_pix/ref_pix are sampled in the same cycle the address is presented.
- Per block: 16 READ + 1 CONV pulse + 16 converter + 1 STORE = 34 cycles.
- start sampled at edge 0: busy=1 after edge 0. decode_done=1 and busy=0 after edge 34·NUM_BLOCKS + 1 (8705 for STR_LEN=512).
- out_string chunk k becomes valid after the STORE edge of block k and holds until restart or reset.

## Configuration
- DECODE_ERR_CHECK_EN defined:
  - any d ∉ {0x00, 0x01, 0xFF} decodes as trit 0 and sets err.
  - a 26-bit accumulator result ≥ 65536 also sets err.
- DECODE_ERR_CHECK_EN undefined: err is tied to 0 and invalid d decodes silently as trit 0. The port still exists.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE, READ, CONV, STORE, DONE)
  - IMG_DIM=64, BLK_DIM=4, TRITS_PER_BLK=16, CHUNK_W=16
  - trit encoding constants
- Sub-module base3_to_base2 #(.TRITS(16)):
  - inputs clk, rst_n, en, base3_no[31:0] (2 bits per trit)
  - outputs base2_no[25:0], done
  - processes the most significant trit first, acc = acc·3 + t, one trit per cycle
  - done pulses 1 cycle after 16 steps

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, FSM stays IDLE.
- All in_pix==ref_pix, STR_LEN=512, start → out_string all zero; decode_done rises exactly 8705 cycles after start; err=0.
- Block 0 green offsets for pixels 0..8 are 0,−1,+1,−1,0,+1,+1,−1,−1 (trits 0,2,1,2,0,1,1,2,2), rest 0 → out_string[15:0]=0x4869 ("Hi").
- Block 0, ref 0x00 / enc 0xFF at pixel 0, rest equal → chunk 0x0002. Ref 0xFF / enc 0x00 at pixel 1 instead → chunk 0x0003.
- Block 3, pixel 5 enc=ref+5:
  - with DECODE_ERR_CHECK_EN: err=1 sticky through decode_done.
  - without the macro: err=0.
  - in both cases that trit decodes as 0.
- Reset mid-decode:
  - rst_n=0 at cycle 100 → row=col=0, busy=0, out_string cleared.
  - a new start completes in 8705 cycles with correct data.
  - start pulsed while busy is ignored (completion cycle unchanged).

Source files
------------

// File: rtl/decode_process_pkg.sv
// Shared types, geometry constants and helpers for the steganographic decoder.
package decode_process_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CONV,
      STORE,
      DONE
   } stateT;

   localparam int IMG_DIM       = 64;
   localparam int BLK_DIM       = 4;
   localparam int TRITS_PER_BLK = BLK_DIM * BLK_DIM;
   localparam int CHUNK_W       = 16;
   localparam int ACC_W         = 26;
   localparam int TRIT_W        = 2;
   localparam int ADDR_W        = $clog2(IMG_DIM);

   localparam logic [1:0] TRIT_ZERO = 2'd0;
   localparam logic [1:0] TRIT_ONE  = 2'd1;
   localparam logic [1:0] TRIT_TWO  = 2'd2;

   localparam logic [7:0] DIFF_ZERO  = 8'h00;
   localparam logic [7:0] DIFF_PLUS  = 8'h01;
   localparam logic [7:0] DIFF_MINUS = 8'hFF;

   // Block b, pixel p -> {row, col}; blocks and pixels are both row-major.
   function automatic logic [2*ADDR_W-1:0] pixAddr(input logic [7:0] blk, input logic [3:0] pix);
      pixAddr = {blk[7:4], pix[3:2], blk[3:0], pix[1:0]};
   endfunction

   // Returns {invalid, trit}; the green difference wraps mod 256 on purpose.
   function automatic logic [2:0] decodeTrit(input logic [7:0] encG, input logic [7:0] refG);
      logic [7:0] diff;
      diff = encG - refG;
      case (diff)
         DIFF_ZERO:  decodeTrit = {1'b0, TRIT_ZERO};
         DIFF_PLUS:  decodeTrit = {1'b0, TRIT_ONE};
         DIFF_MINUS: decodeTrit = {1'b0, TRIT_TWO};
         default:    decodeTrit = {1'b1, TRIT_ZERO};
      endcase
   endfunction

endpackage

// File: rtl/decode_process_if.sv
// Pixel-fetch and result bus between the decoder and its image/host side.
interface decode_process_if #(
   parameter int STR_LEN = 512
);
   logic                 start;
   logic [23:0]          in_pix;
   logic [23:0]          ref_pix;
   logic [5:0]           row;
   logic [5:0]           col;
   logic                 busy;
   logic [8*STR_LEN-1:0] out_string;
   logic                 decode_done;
   logic                 err;

   modport master (
      output start, in_pix, ref_pix,
      input  row, col, busy, out_string, decode_done, err
   );

   modport slave (
      input  start, in_pix, ref_pix,
      output row, col, busy, out_string, decode_done, err
   );
endinterface

// File: rtl/decode_process_base3_to_base2.sv
// Serial Horner converter: 16 trits (MS trit first) into a 26-bit binary value.
module base3_to_base2
   import decode_process_pkg::*;
#(
   parameter int TRITS = TRITS_PER_BLK
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [2*TRITS-1:0]     base3_no,
   output logic [ACC_W-1:0]       base2_no,
   output logic                   done
);
   localparam int CNT_W = $clog2(TRITS) + 1;

   logic [2*TRITS-1:0] r_shift;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_active;
   logic               r_done;
   logic [1:0]         w_topTrit;
   logic [ACC_W-1:0]   w_stepAcc;

   // The enable cycle already folds in the top trit, so done lands with the last step.
   assign w_topTrit = en ? base3_no[2*TRITS-1 -: 2] : r_shift[2*TRITS-1 -: 2];
   assign w_stepAcc = en ? ACC_W'(w_topTrit) : (r_acc << 1) + r_acc + ACC_W'(w_topTrit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift  <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (en) begin
            r_acc    <= w_stepAcc;
            r_shift  <= base3_no << 2;
            r_cnt    <= CNT_W'(1);
            r_active <= 1'b1;
         end else if (r_active) begin
            r_acc   <= w_stepAcc;
            r_shift <= r_shift << 2;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(TRITS - 1)) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
            end
         end
      end
   end

   assign base2_no = r_acc;
   assign done     = r_done;

endmodule

// File: rtl/decode_process.sv
// Steganographic decoder top: walks 4x4 blocks, extracts trits, stores 16-bit chunks.
// Optional DECODE_ERR_CHECK_EN enables the sticky invalid-pixel / overflow err flag.
module decode_process
   import decode_process_pkg::*;
#(
   parameter int STR_LEN = 512
) (
   input  logic            clk,
   input  logic            rst_n,
   decode_process_if.slave bus
);
   localparam int NUM_BLOCKS = STR_LEN / 2;
   localparam int STR_W      = 8 * STR_LEN;

   stateT                        r_state;
   stateT                        w_nextState;
   logic [7:0]                   r_blk;
   logic [3:0]                   r_pix;
   logic [ADDR_W-1:0]            r_row;
   logic [ADDR_W-1:0]            r_col;
   logic [TRIT_W*TRITS_PER_BLK-1:0] r_trits;
   logic [STR_W-1:0]             r_outString;
   logic                         r_decodeDone;
   logic                         r_convStarted;
   logic                         w_startAccept;
   logic                         w_convEn;
   logic                         w_busy;
   logic                         w_lastBlk;
   logic [2:0]                   w_tritInfo;
   logic [ACC_W-1:0]             w_accOut;
   logic                         w_convDone;
   logic                         w_unusedPix;

   assign w_tritInfo  = decodeTrit(bus.in_pix[15:8], bus.ref_pix[15:8]);
   assign w_lastBlk   = (r_blk == 8'(NUM_BLOCKS - 1));
   assign w_unusedPix = ^{bus.in_pix[23:16], bus.in_pix[7:0], bus.ref_pix[23:16], bus.ref_pix[7:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_nextState = READ;
         READ:    if (r_pix == 4'(TRITS_PER_BLK - 1)) w_nextState = CONV;
         CONV:    if (w_convDone) w_nextState = STORE;
         STORE:   w_nextState = w_lastBlk ? DONE : READ;
         DONE:    if (bus.start) w_nextState = READ;
         default: w_nextState = IDLE;
      endcase
   end

   // busy stays up in DONE until decode_done has been registered.
   always_comb begin
      w_startAccept = 1'b0;
      w_convEn      = 1'b0;
      w_busy        = 1'b0;
      case (r_state)
         IDLE:    w_startAccept = bus.start;
         CONV: begin
            w_convEn = !r_convStarted;
            w_busy   = 1'b1;
         end
         DONE: begin
            w_startAccept = bus.start;
            w_busy        = !r_decodeDone;
         end
         default: w_busy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blk         <= '0;
         r_pix         <= '0;
         r_row         <= '0;
         r_col         <= '0;
         r_trits       <= '0;
         r_outString   <= '0;
         r_decodeDone  <= 1'b0;
         r_convStarted <= 1'b0;
      end else begin
         r_convStarted <= (r_state == CONV) && (w_nextState == CONV);
         if (w_startAccept) begin
            r_blk        <= '0;
            r_pix        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_outString  <= '0;
            r_decodeDone <= 1'b0;
         end else begin
            case (r_state)
               READ: begin
                  r_trits[{r_pix, 1'b0} +: TRIT_W] <= w_tritInfo[1:0];
                  r_pix          <= r_pix + 4'd1;
                  {r_row, r_col} <= pixAddr(r_blk, r_pix + 4'd1);
               end
               STORE: begin
                  r_outString[{r_blk, 4'b0000} +: CHUNK_W] <= w_accOut[CHUNK_W-1:0];
                  r_blk          <= r_blk + 8'd1;
                  {r_row, r_col} <= pixAddr(r_blk + 8'd1, 4'd0);
               end
               DONE:    r_decodeDone <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   base3_to_base2 #(
      .TRITS (TRITS_PER_BLK)
   ) u_conv (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_convEn),
      .base3_no (r_trits),
      .base2_no (w_accOut),
      .done     (w_convDone)
   );

`ifdef DECODE_ERR_CHECK_EN
   logic r_err;

   // Sticky until the next accepted start; covers bad pixel deltas and >16-bit chunks.
   always_ff @(posedge clk) begin
      if (!rst_n)                                              r_err <= 1'b0;
      else if (w_startAccept)                                  r_err <= 1'b0;
      else if (r_state == READ && w_tritInfo[2])               r_err <= 1'b1;
      else if (r_state == STORE && |w_accOut[ACC_W-1:CHUNK_W]) r_err <= 1'b1;
   end

   assign bus.err = r_err;
`else
   logic w_unusedErr;
   assign w_unusedErr = w_tritInfo[2] ^ (|w_accOut[ACC_W-1:CHUNK_W]);
   assign bus.err     = 1'b0;
`endif

   assign bus.row         = r_row;
   assign bus.col         = r_col;
   assign bus.busy        = w_busy;
   assign bus.out_string  = r_outString;
   assign bus.decode_done = r_decodeDone;

endmodule

// File: tb/tb_decode_process.sv
// Scoreboard bench for decode_process: directed images, expected chunks queued per run.
module tb_decode_process;
   localparam int STR_LEN     = 512;
   localparam int STR_W       = 8 * STR_LEN;
   localparam int EXP_LATENCY = 34 * (STR_LEN / 2) + 1;
`ifdef DECODE_ERR_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   typedef struct {
      int               runId;
      longint           startEdge;
      logic [STR_W-1:0] str;
      logic             errFlag;
   } expT;

   logic        clk = 1'b0;
   logic        rst_n;
   longint      cyc = 0;
   int          compared = 0;
   int          mismatched = 0;
   logic        prevDone = 1'b0;
   logic [23:0] encMem [0:4095];
   logic [23:0] refMem [0:4095];
   expT         expQ [$];
   expT         monItem;

   decode_process_if #(.STR_LEN(STR_LEN)) bus ();

   decode_process #(.STR_LEN(STR_LEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.in_pix  = encMem[{bus.row, bus.col}];
   assign bus.ref_pix = refMem[{bus.row, bus.col}];

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkString(input string name, input logic [STR_W-1:0] actual, input logic [STR_W-1:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         for (int k = 0; k < STR_LEN / 2; k++) begin
            if (actual[16*k +: 16] !== expected[16*k +: 16]) begin
               $display("[TB] FAIL %s: chunk %0d actual 0x%04h, expected 0x%04h",
                        name, k, actual[16*k +: 16], expected[16*k +: 16]);
               break;
            end
         end
      end
   endtask

   // Monitor: every rising decode_done retires one queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.decode_done === 1'b1 && prevDone !== 1'b1) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected decode_done: actual 1 at cycle %0d, expected no completion", cyc);
         end else begin
            monItem = expQ.pop_front();
            checkOutput($sformatf("run%0d latency", monItem.runId), 64'(cyc - monItem.startEdge), 64'(EXP_LATENCY));
            checkOutput($sformatf("run%0d busy at done", monItem.runId), bus.busy, 0);
            checkOutput($sformatf("run%0d err", monItem.runId), bus.err, monItem.errFlag);
            checkString($sformatf("run%0d out_string", monItem.runId), bus.out_string, monItem.str);
         end
      end
      prevDone = bus.decode_done;
   end

   // Random red/blue everywhere so a decoder looking outside green breaks.
   task automatic setupImage();
      logic [7:0] g;
      for (int i = 0; i < 4096; i++) begin
         g = 8'(i * 37 + 11);
         refMem[i] = {8'($urandom), g, 8'($urandom)};
         encMem[i] = {8'($urandom), g, 8'($urandom)};
      end
   endtask

   task automatic setOffset(input int r, input int c, input logic [7:0] off);
      encMem[r*64 + c][15:8] = refMem[r*64 + c][15:8] + off;
   endtask

   task automatic setPair(input int r, input int c, input logic [7:0] refG, input logic [7:0] encG);
      refMem[r*64 + c][15:8] = refG;
      encMem[r*64 + c][15:8] = encG;
   endtask

   // "Hi" in block 0 plus an invalid delta (+5) at block 3 pixel 5 (row 1, col 13).
   task automatic loadHiImage();
      logic [7:0] offs [9];
      offs = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF};
      setupImage();
      for (int p = 0; p < 9; p++) setOffset(p / 4, p % 4, offs[p]);
      setOffset(1, 13, 8'd5);
   endtask

   task automatic applyStimulus(input int runId, input logic [STR_W-1:0] expStr, input logic expErr,
                                input int busyPulseAt, input bit checkAddr);
      expT item;
      bit  seen;
      @(negedge clk);
      bus.start      = 1'b1;
      item.runId     = runId;
      item.startEdge = cyc + 1;
      item.str       = expStr;
      item.errFlag   = expErr;
      expQ.push_back(item);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput($sformatf("run%0d busy after start", runId), bus.busy, 1);
      checkOutput($sformatf("run%0d done cleared", runId), bus.decode_done, 0);
      checkOutput($sformatf("run%0d err cleared", runId), bus.err, 0);
      checkString($sformatf("run%0d string cleared", runId), bus.out_string, '0);
      seen = 1'b0;
      for (int i = 1; i < EXP_LATENCY + 200; i++) begin
         @(negedge clk);
         if (checkAddr && i == 5) begin
            checkOutput("row after edge 5", bus.row, 1);
            checkOutput("col after edge 5", bus.col, 1);
         end
         bus.start = (i == busyPulseAt);
         if (bus.decode_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      bus.start = 1'b0;
      if (!seen) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL run%0d completion: actual no decode_done, expected within %0d cycles", runId, EXP_LATENCY);
      end
   endtask

   initial begin
      logic [STR_W-1:0] e;
      rst_n     = 1'b0;
      bus.start = 1'b1;
      setupImage();
      repeat (3) @(negedge clk);
      checkOutput("reset row", bus.row, 0);
      checkOutput("reset col", bus.col, 0);
      checkOutput("reset busy", bus.busy, 0);
      checkOutput("reset done", bus.decode_done, 0);
      checkOutput("reset err", bus.err, 0);
      checkString("reset out_string", bus.out_string, '0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle busy after reset", bus.busy, 0);

      $display("[TB] run1: identical images");
      e = '0;
      applyStimulus(1, e, 1'b0, 0, 1'b1);

      $display("[TB] run2: Hi in block 0, invalid delta in block 3");
      loadHiImage();
      e = '0;
      e[15:0] = 16'h4869;
      applyStimulus(2, e, ERR_EN, 0, 1'b0);

      $display("[TB] run3: wrap to trit 2 at pixel 0, top trit of last block");
      setupImage();
      setPair(0, 0, 8'h00, 8'hFF);
      setOffset(63, 63, 8'h01);
      e = '0;
      e[15:0] = 16'h0002;
      e[STR_W-1 -: 16] = 16'hF26B;
      applyStimulus(3, e, ERR_EN, 0, 1'b0);

      $display("[TB] run4: wrap to trit 1 at pixel 1");
      setupImage();
      setPair(0, 1, 8'hFF, 8'h00);
      e = '0;
      e[15:0] = 16'h0003;
      applyStimulus(4, e, 1'b0, 0, 1'b0);

      $display("[TB] reset during decode");
      loadHiImage();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (99) @(negedge clk);
      checkOutput("chunk0 before abort", bus.out_string[15:0], 16'h4869);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checkOutput("abort row", bus.row, 0);
      checkOutput("abort col", bus.col, 0);
      checkOutput("abort busy", bus.busy, 0);
      checkOutput("abort done", bus.decode_done, 0);
      checkString("abort out_string", bus.out_string, '0);

      $display("[TB] run5: fresh decode with ignored start while busy");
      e = '0;
      e[15:0] = 16'h4869;
      applyStimulus(5, e, ERR_EN, 500, 1'b0);

      @(negedge clk);
      checkOutput("scoreboard drained", 64'(expQ.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
